// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_gen #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) cnt <= '0;
        else          cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin time-sliced owner of the LED bank, with a one-tick dark gap between owners.
// Optional LED_ARB_BLINK_EN: 1 Hz blink of the owner's pattern, phase restarted on each grant.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 1000,
    parameter int NREQ        = 4,
    parameter int LED_W       = 8,
    parameter int SLICE_TICKS = 1000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LED_W-1:0]   pattern,
    output logic [NREQ-1:0]         gnt,
    output logic [LED_W-1:0]        LEDG,
    output logic                    busy
);

    localparam int OW = $clog2(NREQ);
    localparam int SW = (SLICE_TICKS > 1) ? $clog2(SLICE_TICKS) : 1;

    arb_state_e                   state;
    logic [OW-1:0]                rr_ptr, owner, pick, idx;
    logic [SW-1:0]                slice_cnt;
    logic                         tick, slice_end, others;
    logic [NREQ-1:0][LED_W-1:0]   pats;
    logic [LED_W-1:0]             mask;

    tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .tick     (tick)
    );

    assign pats      = pattern;
    assign busy      = (state != IDLE);
    assign slice_end = tick && (slice_cnt == SW'(SLICE_TICKS - 1));
    assign others    = |(req & ~gnt);

    // Descending scan so the candidate nearest rr_ptr is the one that sticks.
    always_comb begin
        pick = rr_ptr;
        idx  = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = OW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) pick = idx;
        end
    end

`ifdef LED_ARB_BLINK_EN
    localparam int HALF = (TICK_HZ / 2 > 0) ? TICK_HZ / 2 : 1;
    localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic          phase, phase_nxt;
    logic [PW-1:0] phase_cnt, phase_cnt_nxt;

    // Phase is held at 1 while idle so every new grant starts lit.
    always_comb begin
        phase_nxt     = phase;
        phase_cnt_nxt = phase_cnt;
        if (state == IDLE) begin
            phase_nxt     = 1'b1;
            phase_cnt_nxt = '0;
        end else if (state == GRANT && tick) begin
            if (phase_cnt == PW'(HALF - 1)) begin
                phase_cnt_nxt = '0;
                phase_nxt     = ~phase;
            end else begin
                phase_cnt_nxt = phase_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            phase     <= 1'b1;
            phase_cnt <= '0;
        end else begin
            phase     <= phase_nxt;
            phase_cnt <= phase_cnt_nxt;
        end
    end

    assign mask = {LED_W{phase_nxt}};
`else
    assign mask = '1;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            slice_cnt <= '0;
            gnt       <= '0;
            LEDG      <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    state     <= GRANT;
                    owner     <= pick;
                    slice_cnt <= '0;
                    gnt       <= NREQ'(1) << pick;
                    LEDG      <= pats[pick] & mask;
                end
                GRANT: begin
                    LEDG <= pats[owner] & mask;
                    if (!req[owner] || (slice_end && others)) begin
                        state  <= GAP;
                        gnt    <= '0;
                        LEDG   <= '0;
                        rr_ptr <= OW'(rr_next(int'(owner), NREQ));
                    end else if (tick) begin
                        slice_cnt <= slice_end ? '0 : slice_cnt + SW'(1);
                    end
                end
                GAP: if (tick) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter at 10 cycles/tick, 3-tick slices.
module tb_led_bank_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] led;
        logic       busy;
    } exp_t;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic [3:0]  req      = '0;
    logic [31:0] pattern  = '0;
    logic [3:0]  gnt;
    logic [7:0]  LEDG;
    logic        busy;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    led_bank_arbiter #(
        .CLK_HZ(100), .TICK_HZ(10), .NREQ(4), .LED_W(8), .SLICE_TICKS(3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .req      (req),
        .pattern  (pattern),
        .gnt      (gnt),
        .LEDG     (LEDG),
        .busy     (busy)
    );

    // Expected outputs for the next n cycles (one entry per rising edge).
    task automatic push(input int n, input logic [3:0] g, input logic [7:0] l, input logic b);
        repeat (n) sb.push_back(exp_t'{g, l, b});
    endtask

    // Reset, then release on a falling edge so the next rising edge is edge 1.
    task automatic start(input logic [3:0] r);
        RESET_N = 1'b0;
        req     = r;
        sb.delete();
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        pattern = {8'h44, 8'h33, 8'h22, 8'h0A};
        RESET_N = 1'b0;
        req     = 4'hF;
        repeat (3) @(negedge CLOCK_50);
        tests++;
        if ({gnt, LEDG, busy} !== 13'd0) begin
            fails++;
            $display("FAIL reset_hold: got gnt=%b led=%h busy=%b, want all 0", gnt, LEDG, busy);
        end
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        tests++;
        if (gnt !== 4'b0001 || LEDG !== 8'h0A || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: got gnt=%b led=%h busy=%b, want 0001/0a/1", gnt, LEDG, busy);
        end
    endtask

    task automatic test_round_robin();
        int n;
        pattern = {8'h33, 8'h00, 8'h11, 8'h00};
        start(4'b1010);
        push(29, 4'b0010, 8'h11, 1'b1);
        push(10, 4'b0000, 8'h00, 1'b1);
        push(1,  4'b0000, 8'h00, 1'b0);
        push(29, 4'b1000, 8'h33, 1'b1);
        push(10, 4'b0000, 8'h00, 1'b1);
        push(1,  4'b0000, 8'h00, 1'b0);
        push(10, 4'b0010, 8'h11, 1'b1);
        n = sb.size();
        for (int e = 1; e <= n; e++) begin
            exp_t x;
            @(negedge CLOCK_50);
            x = sb.pop_front();
            tests++;
            if ({gnt, LEDG, busy} !== x) begin
                fails++;
                $display("FAIL round_robin edge %0d: got gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         e, gnt, LEDG, busy, x.gnt, x.led, x.busy);
            end
        end
    endtask

    task automatic test_sole_requester();
        int n;
        pattern = {8'h00, 8'h44, 8'h00, 8'h00};
        start(4'b0100);
        push(50, 4'b0100, 8'h44, 1'b1);
        push(50, 4'b0100, 8'h55, 1'b1);
        n = sb.size();
        for (int e = 1; e <= n; e++) begin
            exp_t x;
            @(negedge CLOCK_50);
            x = sb.pop_front();
            tests++;
            if ({gnt, LEDG, busy} !== x) begin
                fails++;
                $display("FAIL sole edge %0d: got gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         e, gnt, LEDG, busy, x.gnt, x.led, x.busy);
            end
            if (e == 50) pattern[23:16] = 8'h55;
        end
    endtask

    task automatic test_early_release();
        int n;
        pattern = {8'h00, 8'h00, 8'hBB, 8'hAA};
        start(4'b0011);
        push(12, 4'b0001, 8'hAA, 1'b1);
        push(7,  4'b0000, 8'h00, 1'b1);
        push(1,  4'b0000, 8'h00, 1'b0);
        push(10, 4'b0010, 8'hBB, 1'b1);
        n = sb.size();
        for (int e = 1; e <= n; e++) begin
            exp_t x;
            @(negedge CLOCK_50);
            x = sb.pop_front();
            tests++;
            if ({gnt, LEDG, busy} !== x) begin
                fails++;
                $display("FAIL early_release edge %0d: got gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         e, gnt, LEDG, busy, x.gnt, x.led, x.busy);
            end
            if (e == 12) req = 4'b0010;
        end
    endtask

    task automatic test_reset_mid_slice();
        int n;
        pattern = {8'h00, 8'h24, 8'h12, 8'h00};
        start(4'b0110);
        push(29, 4'b0010, 8'h12, 1'b1);
        push(10, 4'b0000, 8'h00, 1'b1);
        push(1,  4'b0000, 8'h00, 1'b0);
        push(10, 4'b0100, 8'h24, 1'b1);
        n = sb.size();
        for (int e = 1; e <= n; e++) begin
            exp_t x;
            @(negedge CLOCK_50);
            x = sb.pop_front();
            tests++;
            if ({gnt, LEDG, busy} !== x) begin
                fails++;
                $display("FAIL reset_mid edge %0d: got gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         e, gnt, LEDG, busy, x.gnt, x.led, x.busy);
            end
        end
        #2 RESET_N = 1'b0;
        #1;
        tests++;
        if ({gnt, LEDG, busy} !== 13'd0) begin
            fails++;
            $display("FAIL reset_mid_async: got gnt=%b led=%h busy=%b, want all 0", gnt, LEDG, busy);
        end
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        tests++;
        if (gnt !== 4'b0010 || LEDG !== 8'h12 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_restart: got gnt=%b led=%h busy=%b, want 0010/12/1", gnt, LEDG, busy);
        end
    endtask

`ifdef LED_ARB_BLINK_EN
    task automatic test_blink();
        int n;
        pattern = {8'h00, 8'h00, 8'h00, 8'hF0};
        start(4'b0001);
        push(49, 4'b0001, 8'hF0, 1'b1);
        push(50, 4'b0001, 8'h00, 1'b1);
        push(21, 4'b0001, 8'hF0, 1'b1);
        n = sb.size();
        for (int e = 1; e <= n; e++) begin
            exp_t x;
            @(negedge CLOCK_50);
            x = sb.pop_front();
            tests++;
            if ({gnt, LEDG, busy} !== x) begin
                fails++;
                $display("FAIL blink edge %0d: got gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                         e, gnt, LEDG, busy, x.gnt, x.led, x.busy);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
`ifdef LED_ARB_BLINK_EN
        test_blink();
`else
        test_sole_requester();
`endif
        test_early_release();
        test_reset_mid_slice();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
